// File: rtl/dir_len_unit_pkg.sv
// Shared types for the direction/length path (the project's common Types definitions).
// Build-wide constants are macros, so any unit can use them as parameter defaults:
//   `WIDTH    signed fixed-point coordinate width (default 16)
//   `Q_BITS   fractional bits of the coordinate format (default 12, i.e. Q3.12)
//   `TAG_SIZE width of the transaction tag (default 8)
// Types:
//   direction_t          signed x, y, z
//   TaggedDirection      tag + direction
//   TaggedDirection_len  tag + direction + unsigned length

`ifndef WIDTH
`define WIDTH 16
`endif
`ifndef Q_BITS
`define Q_BITS 12
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package dir_len_unit_pkg;

   typedef struct packed {
      logic signed [`WIDTH-1:0] x;
      logic signed [`WIDTH-1:0] y;
      logic signed [`WIDTH-1:0] z;
   } direction_t;

   typedef struct packed {
      logic [`TAG_SIZE-1:0] tag;
      direction_t           direction;
   } TaggedDirection;

   typedef struct packed {
      logic [`TAG_SIZE-1:0] tag;
      direction_t           direction;
      logic [`WIDTH-1:0]    len;
   } TaggedDirection_len;

endpackage

// File: rtl/dir_len_unit_isqrt_seq.sv
// isqrt_seq: bit-serial restoring integer square root, two radicand bits per cycle.
// The first step is taken on the loading edge, so a RAD_W-bit radicand finishes
// after RAD_W/2 edges with done high for one cycle and root valid from then on.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start_i      load rad_i and begin (ignored while busy)
//   rad_i        unsigned radicand, RAD_W bits (RAD_W must be even)
//   busy_o       iterations still pending
//   done_o       one-cycle pulse: root_o holds floor(sqrt(rad_i))
//   root_o       result, RAD_W/2 bits

module isqrt_seq #(
   parameter int unsigned RAD_W = 34
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [RAD_W-1:0]   rad_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [RAD_W/2-1:0] root_o
);

   localparam int unsigned ROOT_W = RAD_W / 2;
   localparam int unsigned REM_W  = ROOT_W + 1;
   localparam int unsigned CNT_W  = $clog2(ROOT_W + 1);

   logic [RAD_W-1:0]  rad_q,  rad_d;
   logic [REM_W-1:0]  rem_q,  rem_d;
   logic [ROOT_W-1:0] root_q, root_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              load_c;
   logic [RAD_W-1:0]  src_rad_c;
   logic [REM_W-1:0]  src_rem_c;
   logic [ROOT_W-1:0] src_root_c;
   logic [REM_W+1:0]  shifted_c, trial_c;
   logic [REM_W-1:0]  rem_step_c;
   logic [ROOT_W-1:0] root_step_c;

   // One restoring step, fed from the radicand input on the loading edge.
   always_comb begin
      load_c     = start_i && !busy_q;
      src_rad_c  = load_c ? rad_i : rad_q;
      src_rem_c  = load_c ? '0    : rem_q;
      src_root_c = load_c ? '0    : root_q;
      shifted_c  = {src_rem_c, src_rad_c[RAD_W-1 -: 2]};
      trial_c    = {1'b0, src_root_c, 2'b01};
      if (shifted_c >= trial_c) begin
         rem_step_c  = REM_W'(shifted_c - trial_c);
         root_step_c = {src_root_c[ROOT_W-2:0], 1'b1};
      end else begin
         rem_step_c  = REM_W'(shifted_c);
         root_step_c = {src_root_c[ROOT_W-2:0], 1'b0};
      end
   end

   // Iteration control: counter holds the steps still to run after this edge.
   always_comb begin
      rad_d  = rad_q;
      rem_d  = rem_q;
      root_d = root_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (load_c) begin
         rad_d  = rad_i << 2;
         rem_d  = rem_step_c;
         root_d = root_step_c;
         cnt_d  = CNT_W'(ROOT_W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rad_d  = rad_q << 2;
         rem_d  = rem_step_c;
         root_d = root_step_c;
         cnt_d  = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign root_o = root_q;

endmodule

// File: rtl/dir_len_unit.sv
// dir_len_unit: measures the Euclidean length of a tagged fixed-point direction
// and hands tag, direction and length to the divider cluster with a start pulse.
// Flow: IDLE (accept) -> SQUARE (sum of squares) -> SQRT (WIDTH+1 cycles) -> ISSUE.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   in_valid     TD_in holds a direction to measure
//   in_ready     high only in IDLE
//   TD_in        tag + signed x, y, z
//   div_ready    divider cluster can take the result
//   start        one-cycle launch pulse (first ISSUE cycle with div_ready)
//   TDL_out      tag, direction, len; stable from ISSUE entry until the next one
// Build option: LEN_ZERO_GUARD_EN replaces a zero length by 1.0 (1 << Q_BITS).

module dir_len_unit
   import dir_len_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = `WIDTH,
   parameter int unsigned Q_BITS = `Q_BITS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  TaggedDirection     TD_in,
   input  logic               div_ready,
   output logic               start,
   output TaggedDirection_len TDL_out
);

   localparam int unsigned PROD_W  = 2 * WIDTH;
   localparam int unsigned SUM_W   = 2 * WIDTH + 2;
   localparam int unsigned LEN_MAX = (1 << (WIDTH - 1)) - 1;
   localparam int unsigned LEN_ONE = 1 << Q_BITS;
`ifdef LEN_ZERO_GUARD_EN
   localparam bit ZERO_GUARD = 1'b1;
`else
   localparam bit ZERO_GUARD = 1'b0;
`endif

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SQUARE = 2'd1;
   localparam logic [1:0] S_SQRT   = 2'd2;
   localparam logic [1:0] S_ISSUE  = 2'd3;

   logic [1:0]         state_q, state_d;
   TaggedDirection     cap_q,   cap_d;
   TaggedDirection_len tdl_q,   tdl_d;

   logic signed [PROD_W-1:0] px_c, py_c, pz_c;
   logic [SUM_W-1:0]         sum_c;
   logic [WIDTH-1:0]         len_sat_c, len_c;
   logic                     sqrt_start, sqrt_busy, sqrt_done;
   logic [WIDTH:0]           sqrt_root;

   // Sum of squares of the captured vector; registered by the sqrt unit on load.
   always_comb begin
      px_c  = PROD_W'($signed(cap_q.direction.x)) * PROD_W'($signed(cap_q.direction.x));
      py_c  = PROD_W'($signed(cap_q.direction.y)) * PROD_W'($signed(cap_q.direction.y));
      pz_c  = PROD_W'($signed(cap_q.direction.z)) * PROD_W'($signed(cap_q.direction.z));
      sum_c = SUM_W'($unsigned(px_c)) + SUM_W'($unsigned(py_c)) + SUM_W'($unsigned(pz_c));
   end

   isqrt_seq #(
      .RAD_W (SUM_W)
   ) u_isqrt (
      .clk     (clk),
      .reset   (reset),
      .start_i (sqrt_start),
      .rad_i   (sum_c),
      .busy_o  (sqrt_busy),
      .done_o  (sqrt_done),
      .root_o  (sqrt_root)
   );

   // Root of a Q(2*Q_BITS) square is already Q(Q_BITS); clamp to the signed max.
   always_comb begin
      len_sat_c = (sqrt_root > (WIDTH+1)'(LEN_MAX)) ? WIDTH'(LEN_MAX) : sqrt_root[WIDTH-1:0];
      len_c     = (ZERO_GUARD && (len_sat_c == '0)) ? WIDTH'(LEN_ONE) : len_sat_c;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      tdl_d      = tdl_q;
      sqrt_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               cap_d   = TD_in;
               state_d = S_SQUARE;
            end
         end
         S_SQUARE: begin
            if (!sqrt_busy) begin
               sqrt_start = 1'b1;
               state_d    = S_SQRT;
            end
         end
         S_SQRT: begin
            if (sqrt_done) begin
               tdl_d.tag       = cap_q.tag;
               tdl_d.direction = cap_q.direction;
               tdl_d.len       = len_c;
               state_d         = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (div_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cap_q   <= '0;
         tdl_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         tdl_q   <= tdl_d;
      end
   end

   // start follows div_ready in the same cycle so the launch is never delayed.
   assign in_ready = (state_q == S_IDLE);
   assign start    = (state_q == S_ISSUE) && div_ready;
   assign TDL_out  = tdl_q;

endmodule

// File: tb/tb_dir_len_unit.sv
// Bench for dir_len_unit: directed vectors, back-pressure, zero vector,
// reset during computation and back-to-back random vectors against a
// real-arithmetic length model.

module tb_dir_len_unit;
   import dir_len_unit_pkg::*;

   localparam int unsigned W   = `WIDTH;
   localparam int          LAT = `WIDTH + 3;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   TaggedDirection     td_in;
   logic               div_ready;
   logic               start;
   TaggedDirection_len tdl_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dir_len_unit dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .TD_in     (td_in),
      .div_ready (div_ready),
      .start     (start),
      .TDL_out   (tdl_out)
   );

   // Length model: exact floor(sqrt(x^2+y^2+z^2)), clamp, optional zero guard.
   function automatic logic [W-1:0] model_len(input logic signed [W-1:0] x, y, z);
      longint lx = longint'(x);
      longint ly = longint'(y);
      longint lz = longint'(z);
      longint s  = lx * lx + ly * ly + lz * lz;
      longint r  = longint'($floor($sqrt(real'(s))));
      longint mx = (longint'(1) << (W - 1)) - 1;
      while (r * r > s) r--;
      while ((r + 1) * (r + 1) <= s) r++;
      if (r > mx) r = mx;
`ifdef LEN_ZERO_GUARD_EN
      if (r == 0) r = longint'(1) << `Q_BITS;
`endif
      return W'(r);
   endfunction

   function automatic TaggedDirection_len model_tdl(input logic [`TAG_SIZE-1:0] tag,
                                                   input logic signed [W-1:0] x, y, z);
      TaggedDirection_len t;
      t.tag         = tag;
      t.direction.x = x;
      t.direction.y = y;
      t.direction.z = z;
      t.len         = model_len(x, y, z);
      return t;
   endfunction

   // Offer one vector, then watch for the start pulse (bounded).
   task automatic send(input logic [`TAG_SIZE-1:0] tag, input logic signed [W-1:0] x, y, z,
                       output int wait_cyc, output int lat, output TaggedDirection_len got,
                       output bit ok);
      wait_cyc = 0;
      lat      = 0;
      ok       = 1'b0;
      got      = '0;
      @(negedge clk);
      while (in_ready !== 1'b1 && wait_cyc < 100) begin
         @(negedge clk);
         wait_cyc++;
      end
      td_in.tag         = tag;
      td_in.direction.x = x;
      td_in.direction.y = y;
      td_in.direction.z = z;
      in_valid          = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (start === 1'b1) begin
            ok  = 1'b1;
            got = tdl_out;
         end else begin
            lat++;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++;
      if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", start); end
      n_checks++;
      if (tdl_out !== '0) begin n_fail++; $display("FAIL reset_tdl got=%h exp=0", tdl_out); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed;
      logic [`TAG_SIZE-1:0]    tags [4] = '{8'd5, 8'd9, 8'd3, 8'd12};
      logic signed [W-1:0]     xs   [4] = '{16'sh1000, 16'sh1000, -16'sh3000, 16'sh7FFF};
      logic signed [W-1:0]     ys   [4] = '{16'sh0000, 16'sh1000,  16'sh4000, 16'sh7FFF};
      logic signed [W-1:0]     zs   [4] = '{16'sh0000, 16'sh1000,  16'sh0000, 16'sh7FFF};
      logic [W-1:0]            lens [4] = '{16'h1000, 16'h1BB6, 16'h5000, 16'h7FFF};
      int wc, lat;
      bit ok;
      TaggedDirection_len got;
      for (int i = 0; i < 4; i++) begin
         send(tags[i], xs[i], ys[i], zs[i], wc, lat, got, ok);
         n_checks++;
         if (!ok) begin n_fail++; $display("FAIL dir%0d_start_seen got=0 exp=1", i); end
         n_checks++;
         if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
         n_checks++;
         if (got.len !== lens[i]) begin n_fail++; $display("FAIL dir%0d_len got=%h exp=%h", i, got.len, lens[i]); end
         n_checks++;
         if (got.tag !== tags[i]) begin n_fail++; $display("FAIL dir%0d_tag got=%h exp=%h", i, got.tag, tags[i]); end
         n_checks++;
         if (got.direction !== {xs[i], ys[i], zs[i]}) begin
            n_fail++;
            $display("FAIL dir%0d_direction got=%h exp=%h", i, got.direction, {xs[i], ys[i], zs[i]});
         end
         @(negedge clk);
         n_checks++;
         if (start !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dir%0d_after_pulse start=%b in_ready=%b exp start=0 in_ready=1", i, start, in_ready);
         end
      end
   endtask

   task automatic test_backpressure;
      TaggedDirection_len exp_t, snap;
      exp_t     = model_tdl(8'hA7, 16'sh0800, -16'sh0600, 16'sh0000);
      div_ready = 1'b0;
      @(negedge clk);
      td_in.tag       = exp_t.tag;
      td_in.direction = exp_t.direction;
      in_valid        = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (LAT) @(negedge clk);
      snap = tdl_out;
      n_checks++;
      if (snap !== exp_t) begin n_fail++; $display("FAIL bp_issue_tdl got=%h exp=%h", snap, exp_t); end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (start !== 1'b0 || in_ready !== 1'b0 || tdl_out !== exp_t) begin
            n_fail++;
            $display("FAIL bp_hold%0d start=%b in_ready=%b tdl=%h exp start=0 in_ready=0 tdl=%h",
                     i, start, in_ready, tdl_out, exp_t);
         end
         @(negedge clk);
      end
      div_ready = 1'b1;
      #1;
      n_checks++;
      if (start !== 1'b1) begin n_fail++; $display("FAIL bp_release_start got=%b exp=1", start); end
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_single_pulse start=%b in_ready=%b exp start=0 in_ready=1", start, in_ready);
      end
   endtask

   task automatic test_zero;
      int wc, lat;
      bit ok;
      TaggedDirection_len got;
      logic [W-1:0] exp_len;
`ifdef LEN_ZERO_GUARD_EN
      exp_len = 16'h1000;
`else
      exp_len = 16'h0000;
`endif
      send(8'h11, 16'sh0000, 16'sh0000, 16'sh0000, wc, lat, got, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL zero_start_seen got=0 exp=1"); end
      n_checks++;
      if (got.len !== exp_len) begin n_fail++; $display("FAIL zero_len got=%h exp=%h", got.len, exp_len); end
   endtask

   task automatic test_reset_mid;
      int wc, lat;
      bit ok, seen;
      TaggedDirection_len got;
      @(negedge clk);
      td_in.tag         = 8'h3C;
      td_in.direction.x = 16'sh2000;
      td_in.direction.y = 16'sh1000;
      td_in.direction.z = 16'sh0400;
      in_valid          = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (start !== 1'b0 || tdl_out !== '0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_async start=%b tdl=%h in_ready=%b exp 0/0/1", start, tdl_out, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (start !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL midrst_no_pulse got=1 exp=0"); end
      send(8'h3D, 16'sh3000, 16'sh0000, 16'sh0000, wc, lat, got, ok);
      n_checks++;
      if (!ok || lat != LAT || got.len !== 16'h3000 || got.tag !== 8'h3D) begin
         n_fail++;
         $display("FAIL midrst_next ok=%b lat=%0d len=%h tag=%h exp ok=1 lat=%0d len=3000 tag=3d",
                  ok, lat, got.len, got.tag, LAT);
      end
   endtask

   task automatic test_back_to_back;
      int wc, lat;
      bit ok;
      TaggedDirection_len got, exp_t;
      logic signed [W-1:0] x, y, z;
      logic [`TAG_SIZE-1:0] tag;
      for (int i = 0; i < 30; i++) begin
         tag = `TAG_SIZE'($urandom);
         if (i % 5 == 4) begin
            x = W'($signed($urandom_range(0, 6)) - 3);
            y = W'($signed($urandom_range(0, 6)) - 3);
            z = W'($signed($urandom_range(0, 6)) - 3);
         end else begin
            x = W'($urandom);
            y = W'($urandom);
            z = W'($urandom);
         end
         exp_t = model_tdl(tag, x, y, z);
         send(tag, x, y, z, wc, lat, got, ok);
         n_checks++;
         if (!ok || lat != LAT) begin
            n_fail++;
            $display("FAIL rnd%0d_timing ok=%b lat=%0d exp ok=1 lat=%0d", i, ok, lat, LAT);
         end
         n_checks++;
         if (got !== exp_t) begin n_fail++; $display("FAIL rnd%0d_tdl got=%h exp=%h", i, got, exp_t); end
         if (i > 0) begin
            n_checks++;
            if (wc != 0) begin n_fail++; $display("FAIL rnd%0d_throughput wait=%0d exp=0", i, wc); end
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      div_ready = 1'b1;
      td_in     = '0;
      test_reset;
      test_directed;
      test_backpressure;
      test_zero;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dir_len_unit.md
DIR_LEN_UNIT -- requirements
Module: dir_len_unit

Interface
REQ-001 SHALL have parameter WIDTH, default `WIDTH, meaning signed fixed-point coordinate width.
REQ-002 SHALL have parameter Q_BITS, default `Q_BITS, meaning fractional bits (Q3.12).
REQ-003 SHALL have clk  input  1  sole clock, rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have in_valid  input  1  TD_in holds a direction to measure.
REQ-006 SHALL have in_ready  output  1  block can accept TD_in this cycle.
REQ-007 SHALL have TD_in  input  TaggedDirection  tag plus signed direction x,y,z.
REQ-008 SHALL have div_ready  input  1  downstream divider cluster ready.
REQ-009 SHALL have start  output  1  single-cycle launch pulse to the divider cluster.
REQ-010 SHALL have TDL_out  output  TaggedDirection_len  tag, direction, len.

Function
REQ-011 SHALL implement FSM IDLE -> SQUARE -> SQRT -> ISSUE -> IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE; accept on the rising edge where in_valid & in_ready, capturing tag and x,y,z.
REQ-013 SQUARE (1 cycle) SHALL register s = x*x + y*y + z*z, signed products, unsigned sum width 2*WIDTH+2.
REQ-014 SQRT SHALL run bit-serial restoring integer sqrt of s for exactly WIDTH+1 cycles via an iteration counter; result r = floor(sqrt(s)) is Q(Q_BITS).
REQ-015 len SHALL saturate to 2^(WIDTH-1)-1 when r exceeds it; otherwise len = r.
REQ-016 In ISSUE, start SHALL be 1 for exactly one cycle, in the first ISSUE cycle with div_ready=1; FSM then returns to IDLE.
REQ-017 With div_ready=0 in ISSUE, start SHALL stay 0 and FSM SHALL wait indefinitely.
REQ-018 TDL_out SHALL be valid from entry to ISSUE and SHALL hold stable until the next accepted input's ISSUE entry.
REQ-019 Latency: with div_ready=1, start SHALL be high in cycle WIDTH+3 after the accepting edge (19 for WIDTH=16).
REQ-020 Throughput SHALL be one vector per WIDTH+4 cycles minimum; no input SHALL be accepted outside IDLE.
REQ-021 TDL_out.direction and .tag SHALL equal the captured input unchanged.

Reset
REQ-022 reset SHALL asynchronously force IDLE, start=0, TDL_out=0, counter=0; in_ready=1 in the first cycle after release.
REQ-023 reset mid-SQRT or mid-ISSUE SHALL discard the operation with no start pulse emitted.

Configuration
REQ-024 Macro LEN_ZERO_GUARD_EN defined: a computed len of 0 SHALL be replaced by 1<<Q_BITS (1.0) to prevent divide-by-zero.
REQ-025 LEN_ZERO_GUARD_EN undefined: len 0 SHALL be passed through unchanged; ports identical in both builds.

Structure
REQ-026 TaggedDirection, TaggedDirection_len and the WIDTH, Q_BITS, TAG_SIZE constants SHALL come from shared Types.sv; no local redefinition.
REQ-027 Iterative sqrt SHALL be sub-module isqrt_seq (start/busy/done, parameterised radicand width); squaring and FSM stay in dir_len_unit.

Verification
REQ-028 x=0x1000,y=z=0,tag=5, div_ready=1 -> start one cycle at cycle 19, len=0x1000, tag=5.
REQ-029 x=y=z=0x1000 -> len=0x1BB6 (floor(sqrt(3)*4096)=7094).
REQ-030 x=-0x3000,y=0x4000,z=0 -> len=0x5000; x=y=z=0x7FFF -> len=0x7FFF (saturated).
REQ-031 div_ready=0 for 10 cycles in ISSUE -> start=0, in_ready=0, TDL_out stable; start pulses once on the cycle div_ready rises.
REQ-032 x=y=z=0 -> len=0x1000 with LEN_ZERO_GUARD_EN, 0x0000 without.
REQ-033 reset asserted at SQRT cycle 5 -> no start pulse, TDL_out=0, in_ready=1 after release; next vector processed normally.
